// File: rtl/sevenseg_pkg.sv
// Shared types, constants and the code-to-segment mapping for the 7-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
`timescale 1ns/1ps
package sevenseg_pkg;

    localparam logic [4:0] CODE_BLANK = 5'h13;
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [6:0] SEG_ERR    = 7'h49;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    // Codes 0x10..0x13 are the extra glyphs 'r', 'P', 'E' and blank.
    function automatic logic [6:0] seg_pattern(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'h00:   seg = 7'h40;
            5'h01:   seg = 7'h79;
            5'h02:   seg = 7'h24;
            5'h03:   seg = 7'h30;
            5'h04:   seg = 7'h19;
            5'h05:   seg = 7'h12;
            5'h06:   seg = 7'h02;
            5'h07:   seg = 7'h78;
            5'h08:   seg = 7'h00;
            5'h09:   seg = 7'h18;
            5'h0A:   seg = 7'h08;
            5'h0B:   seg = 7'h03;
            5'h0C:   seg = 7'h46;
            5'h0D:   seg = 7'h21;
            5'h0E:   seg = 7'h06;
            5'h0F:   seg = 7'h0E;
            5'h10:   seg = 7'h2F;
            5'h11:   seg = 7'h0C;
            5'h12:   seg = 7'h06;
            5'h13:   seg = SEG_OFF;
            default: seg = SEG_ERR;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_code_rom.sv
// Combinational digit-code to active-low segment pattern lookup.
`timescale 1ns/1ps
module sevenseg_code_rom
    import sevenseg_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg_pattern(code_i);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with ghost-guard gaps between digits
// and a double-buffered digit bank that only swaps at the frame boundary.
`timescale 1ns/1ps
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 12500,
    parameter int BLANK_CYC  = 16
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5*NUM_DIGITS-1:0] codes_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    load_i,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int CW    = 5 * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(TICK_DIV + BLANK_CYC);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYC - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic [CW-1:0]           act_codes_q, act_codes_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [CW-1:0]           sh_codes_q, sh_codes_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_q, frame_d;

    logic                    show_end;
    logic                    guard_exit;
    logic                    wrap;
    logic [4:0]              sel_code;
    logic                    sel_dp;
    logic                    sel_blank;
    logic [6:0]              rom_seg;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        show_end   = 1'b0;
        guard_exit = 1'b0;
        wrap       = 1'b0;
        if (state_q == ST_SHOW) begin
            if (cnt_q == SHOW_LAST) begin
                cnt_d    = '0;
                state_d  = ST_GUARD;
                show_end = 1'b1;
            end
        end else begin
            if (cnt_q == GUARD_LAST) begin
                cnt_d      = '0;
                state_d    = ST_SHOW;
                guard_exit = 1'b1;
                wrap       = (idx_q == LAST_IDX);
                idx_d      = wrap ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    // A load landing on the wrap edge goes straight into the active bank.
    always_comb begin
        sh_codes_d  = load_i ? codes_i : sh_codes_q;
        sh_dp_d     = load_i ? dp_i    : sh_dp_q;
        sh_blank_d  = load_i ? blank_i : sh_blank_q;
        act_codes_d = act_codes_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        frame_d     = wrap;
        if (wrap) begin
            act_codes_d = load_i ? codes_i : sh_codes_q;
            act_dp_d    = load_i ? dp_i    : sh_dp_q;
            act_blank_d = load_i ? blank_i : sh_blank_q;
        end
    end

    assign sel_code  = act_codes_d[int'(idx_d) * 5 +: 5];
    assign sel_dp    = act_dp_d[idx_d];
    assign sel_blank = act_blank_d[idx_d];

    sevenseg_code_rom u_code_rom (
        .code_i (sel_code),
        .seg_o  (rom_seg)
    );

    // Segments are only reloaded on the guard exit, right after a cycle with all anodes off.
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (show_end) begin
            an_d = '1;
        end
        if (guard_exit) begin
            if (sel_blank) begin
                an_d  = '1;
                seg_d = SEG_OFF;
                dp_d  = 1'b1;
            end else begin
                an_d  = ~(NUM_DIGITS'(1) << idx_d);
                seg_d = rom_seg;
                dp_d  = ~sel_dp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_GUARD;
            cnt_q       <= '0;
            idx_q       <= LAST_IDX;
            act_codes_q <= {NUM_DIGITS{CODE_BLANK}};
            act_dp_q    <= '0;
            act_blank_q <= '0;
            sh_codes_q  <= {NUM_DIGITS{CODE_BLANK}};
            sh_dp_q     <= '0;
            sh_blank_q  <= '0;
            an_q        <= '1;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            act_codes_q <= act_codes_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            sh_codes_q  <= sh_codes_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            frame_q     <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with 4 digits, 10-cycle slots and 2-cycle guards.
// Whole frames are compared cycle by cycle against hand-computed segment values.
`timescale 1ns/1ps
module tb_sevenseg_scan_driver;

    localparam int N     = 4;
    localparam int T     = 10;
    localparam int B     = 2;
    localparam int SLOT  = T + B;
    localparam int FRAME = N * SLOT;

    logic          clk;
    logic          rst;
    logic [5*N-1:0] codes_i;
    logic [N-1:0]  dp_i;
    logic [N-1:0]  blank_i;
    logic          load_i;
    logic [N-1:0]  an_o;
    logic [6:0]    seg_o;
    logic          dp_o;
    logic          frame_o;

    int vec_count  = 0;
    int miss_count = 0;

    sevenseg_scan_driver #(
        .NUM_DIGITS (N),
        .TICK_DIV   (T),
        .BLANK_CYC  (B)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .codes_i (codes_i),
        .dp_i    (dp_i),
        .blank_i (blank_i),
        .load_i  (load_i),
        .an_o    (an_o),
        .seg_o   (seg_o),
        .dp_o    (dp_o),
        .frame_o (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle load strobe, issued from a negedge.
    task automatic applyStimulus(input logic [5*N-1:0] codes, input logic [N-1:0] dp,
                                 input logic [N-1:0] blank);
        codes_i = codes;
        dp_i    = dp;
        blank_i = blank;
        load_i  = 1'b1;
        @(negedge clk);
        load_i  = 1'b0;
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, ".an"},    32'(an_o),    32'h0000000F);
        checkOutput({name, ".seg"},   32'(seg_o),   32'h0000007F);
        checkOutput({name, ".dp"},    32'(dp_o),    32'h00000001);
        checkOutput({name, ".frame"}, 32'(frame_o), 32'h00000000);
    endtask

    // Called at the negedge where frame_o should be high; walks one full frame.
    task automatic checkFrame(input string name, input logic [7*N-1:0] exp_seg,
                              input logic [N-1:0] exp_dp, input logic [N-1:0] exp_blank);
        for (int c = 0; c < FRAME; c++) begin
            int         d     = c / SLOT;
            int         pos   = c % SLOT;
            logic [3:0] e_an;
            logic [6:0] e_seg;
            logic       e_dp;
            e_seg = exp_blank[d] ? 7'h7F : exp_seg[d*7 +: 7];
            e_dp  = exp_blank[d] ? 1'b1 : ~exp_dp[d];
            e_an  = (pos < T && !exp_blank[d]) ? ~(4'b0001 << d) : 4'hF;
            checkOutput($sformatf("%s.an[%0d]", name, c),    32'(an_o),    32'(e_an));
            checkOutput($sformatf("%s.seg[%0d]", name, c),   32'(seg_o),   32'(e_seg));
            checkOutput($sformatf("%s.dp[%0d]", name, c),    32'(dp_o),    32'(e_dp));
            checkOutput($sformatf("%s.frame[%0d]", name, c), 32'(frame_o), 32'(c == 0));
            @(negedge clk);
        end
    endtask

    // Drops reset at a negedge; the initial guard exit lands on the second edge after.
    task automatic releaseReset(input string name);
        rst = 1'b0;
        @(negedge clk);
        checkOutput({name, ".preFrame"}, 32'(frame_o), 32'h0);
        checkOutput({name, ".preAn"},    32'(an_o),    32'hF);
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        load_i  = 1'b0;
        codes_i = '0;
        dp_i    = '0;
        blank_i = '0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        releaseReset("start");

        // Frame A: reset bank (all code 13, lit but dark); load lands mid-frame.
        fork
            checkFrame("A", {4{7'h7F}}, 4'b0000, 4'b0000);
            begin
                repeat (20) @(negedge clk);
                applyStimulus({5'h03, 5'h02, 5'h01, 5'h00}, 4'b0000, 4'b0000);
            end
        join

        // Frame B: shows {3,2,1,0}; two loads inside it, the second must win later.
        fork
            checkFrame("B", {7'h30, 7'h24, 7'h79, 7'h40}, 4'b0000, 4'b0000);
            begin
                repeat (5) @(negedge clk);
                applyStimulus({5'h00, 5'h00, 5'h00, 5'h05}, 4'b0000, 4'b0000);
                repeat (20) @(negedge clk);
                applyStimulus({5'h00, 5'h00, 5'h01, 5'h05}, 4'b0000, 4'b0000);
            end
        join

        // Frame C: second load visible; a load is timed onto the closing wrap edge.
        fork
            checkFrame("C", {7'h40, 7'h40, 7'h79, 7'h12}, 4'b0000, 4'b0000);
            begin
                repeat (FRAME - 1) @(negedge clk);
                applyStimulus({5'h12, 5'h11, 5'h10, 5'h0A}, 4'b0000, 4'b0000);
            end
        join

        // Frame D: bypassed load already shown; next load blanks digit 1 and sets dp on digit 0.
        fork
            checkFrame("D", {7'h06, 7'h0C, 7'h2F, 7'h08}, 4'b0000, 4'b0000);
            begin
                repeat (10) @(negedge clk);
                applyStimulus({5'h13, 5'h11, 5'h1F, 5'h10}, 4'b0001, 4'b0010);
            end
        join

        fork
            checkFrame("E", {7'h7F, 7'h0C, 7'h7F, 7'h2F}, 4'b0001, 4'b0010);
            begin
                repeat (10) @(negedge clk);
                applyStimulus({5'h13, 5'h11, 5'h1F, 5'h10}, 4'b0001, 4'b0000);
            end
        join

        // Frame F: digit 1 unblanked, out-of-range code shows error bars.
        checkFrame("F", {7'h7F, 7'h0C, 7'h49, 7'h2F}, 4'b0001, 4'b0000);

        // Reset while digit 2 is lit.
        repeat (2 * SLOT + 1) @(negedge clk);
        checkOutput("midScan.an",  32'(an_o),  32'hB);
        checkOutput("midScan.seg", 32'(seg_o), 32'h0C);
        rst = 1'b1;
        @(negedge clk);
        checkResetState("midReset");
        releaseReset("restart");
        checkFrame("R", {4{7'h7F}}, 4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
